// File: rtl/types_pkg.sv
// Shared types for the load/store unit: bus width, access size, FSM state and error codes.
package types_pkg;

  localparam int DATA_BUS = 32;
  localparam int STRB_W   = DATA_BUS / 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } lsu_err;

  function automatic logic is_aligned(input mem_size size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~lo[0];
      default:   return (lo == 2'b00);
    endcase
  endfunction

  // Drops the low address bits a half/word access cannot use; no-op for aligned addresses.
  function automatic logic [1:0] fold_offset(input mem_size size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return lo;
      SIZE_HALF: return {lo[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes, store-data replication and load extraction/extension.
module lsu_align
  import types_pkg::*;
(
  input  mem_size                 size,
  input  logic [1:0]              offset,
  input  logic [DATA_BUS-1:0]     store_data,
  input  logic [DATA_BUS-1:0]     load_word,
  input  logic                    load_unsigned,
  output logic [STRB_W-1:0]       wstrb,
  output logic [DATA_BUS-1:0]     wdata_lanes,
  output logic [DATA_BUS-1:0]     load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        byte_sign;
  logic        half_sign;

  always_comb begin
    byte_lane   = load_word[{offset, 3'b000} +: 8];
    half_lane   = offset[1] ? load_word[31:16] : load_word[15:0];
    byte_sign   = ~load_unsigned & byte_lane[7];
    half_sign   = ~load_unsigned & half_lane[15];
    wstrb       = '0;
    wdata_lanes = '0;
    load_data   = '0;
    case (size)
      SIZE_BYTE: begin
        wstrb       = 4'b0001 << offset;
        wdata_lanes = {4{store_data[7:0]}};
        load_data   = {{(DATA_BUS-8){byte_sign}}, byte_lane};
      end
      SIZE_HALF: begin
        wstrb       = 4'b0011 << {offset[1], 1'b0};
        wdata_lanes = {2{store_data[15:0]}};
        load_data   = {{(DATA_BUS-16){half_sign}}, half_lane};
      end
      default: begin
        wstrb       = '1;
        wdata_lanes = store_data;
        load_data   = load_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> REQ -> DONE handshake with a word-aligned memory port and wait timeout.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned accesses with err=01 instead of folding the address.
module load_store_unit
  import types_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  mem_size             req_size,
  input  logic                req_unsigned,
  input  logic [DATA_BUS-1:0] addr,
  input  logic [DATA_BUS-1:0] wdata,
  output logic                stall,
  output logic [DATA_BUS-1:0] rdata,
  output logic                done,
  output logic [1:0]          err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_BUS-1:0] mem_addr,
  output logic [STRB_W-1:0]   mem_wstrb,
  output logic [DATA_BUS-1:0] mem_wdata,
  input  logic                mem_ready,
  input  logic [DATA_BUS-1:0] mem_rdata
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW:0] MAX_CNT = (CW + 1)'(MAX_WAIT);

  lsu_state            state;
  logic [DATA_BUS-1:0] cap_addr;
  logic [DATA_BUS-1:0] cap_wdata;
  mem_size             cap_size;
  logic                cap_we;
  logic                cap_unsigned;
  logic [CW-1:0]       wait_cnt;
  logic [CW:0]         cnt_next;

  logic [STRB_W-1:0]   lane_strb;
  logic [DATA_BUS-1:0] lane_wdata;
  logic [DATA_BUS-1:0] load_data;

  lsu_align u_align (
    .size          (cap_size),
    .offset        (cap_addr[1:0]),
    .store_data    (cap_wdata),
    .load_word     (mem_rdata),
    .load_unsigned (cap_unsigned),
    .wstrb         (lane_strb),
    .wdata_lanes   (lane_wdata),
    .load_data     (load_data)
  );

  assign cnt_next  = {1'b0, wait_cnt} + (CW + 1)'(1);
  assign stall     = ((state == LSU_IDLE) && req_valid) || (state == LSU_REQ);
  assign mem_we    = mem_req & cap_we;
  assign mem_addr  = {cap_addr[DATA_BUS-1:2], 2'b00};
  assign mem_wstrb = (mem_req && cap_we) ? lane_strb : '0;
  assign mem_wdata = lane_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LSU_IDLE;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      cap_size     <= SIZE_BYTE;
      cap_we       <= 1'b0;
      cap_unsigned <= 1'b0;
      wait_cnt     <= '0;
      rdata        <= '0;
      done         <= 1'b0;
      err          <= ERR_OK;
      mem_req      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
`ifdef LSU_MISALIGN_CHECK_EN
            if (!is_aligned(req_size, addr[1:0])) begin
              err   <= ERR_MISALIGN;
              done  <= 1'b1;
              state <= LSU_DONE;
            end else
`endif
            begin
              // Offset folding keeps unchecked misaligned accesses on their containing half/word.
              cap_addr     <= {addr[DATA_BUS-1:2], fold_offset(req_size, addr[1:0])};
              cap_wdata    <= wdata;
              cap_size     <= req_size;
              cap_we       <= req_we;
              cap_unsigned <= req_unsigned;
              wait_cnt     <= '0;
              mem_req      <= 1'b1;
              state        <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (mem_ready) begin
            if (!cap_we) rdata <= load_data;
            err     <= ERR_OK;
            done    <= 1'b1;
            mem_req <= 1'b0;
            state   <= LSU_DONE;
          end else if (cnt_next == MAX_CNT) begin
            rdata   <= '0;
            err     <= ERR_TIMEOUT;
            done    <= 1'b1;
            mem_req <= 1'b0;
            state   <= LSU_DONE;
          end else begin
            wait_cnt <= cnt_next[CW-1:0];
          end
        end
        LSU_DONE: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected memory-side and response entries.
module tb_load_store_unit;
  import types_pkg::*;

  localparam int MAX_WAIT = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_we;
  mem_size             req_size;
  logic                req_unsigned;
  logic [DATA_BUS-1:0] addr;
  logic [DATA_BUS-1:0] wdata;
  logic                stall;
  logic [DATA_BUS-1:0] rdata;
  logic                done;
  logic [1:0]          err;
  logic                mem_req;
  logic                mem_we;
  logic [DATA_BUS-1:0] mem_addr;
  logic [STRB_W-1:0]   mem_wstrb;
  logic [DATA_BUS-1:0] mem_wdata;
  logic                mem_ready;
  logic [DATA_BUS-1:0] mem_rdata;

  load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .rdata        (rdata),
    .done         (done),
    .err          (err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] maddr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] mwdata;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int unsigned start;
    int unsigned lat;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  mem_exp_t  m;
  resp_exp_t r;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every memory handshake and every done pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_ready) begin
        if (mem_q.size() == 0) check("unexpected_mem_handshake", 32'd1, 32'd0);
        else begin
          m = mem_q.pop_front();
          check("mem_addr", mem_addr, m.maddr);
          check("mem_we", {31'd0, mem_we}, {31'd0, m.we});
          check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m.strb});
          if (m.we) check("mem_wdata", mem_wdata, m.mwdata);
        end
      end
      if (done) begin
        if (resp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          r = resp_q.pop_front();
          check("rdata", rdata, r.rdata);
          check("err", {30'd0, err}, {30'd0, r.err});
          check("done_latency", cyc - r.start, r.lat);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic access(input logic we, input mem_size sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                        input int unsigned waits, input logic [31:0] exp_maddr,
                        input logic [3:0] exp_strb, input logic [31:0] exp_mwdata,
                        input logic [31:0] exp_rdata);
    tick;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; addr = a; wdata = wd;
    mem_q.push_back('{exp_maddr, we, exp_strb, exp_mwdata});
    resp_q.push_back('{exp_rdata, 2'b00, cyc, waits + 2});
    tick;
    // Scramble the request inputs to prove the captured copy drives memory.
    req_valid = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0; req_size = SIZE_BYTE; req_unsigned = ~uns;
    check("stall_in_req", {31'd0, stall}, 32'd1);
    repeat (waits) tick;
    mem_ready = 1'b1; mem_rdata = rword;
    tick;
    mem_ready = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    check("stall_in_done", {31'd0, stall}, 32'd0);
    tick;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SIZE_WORD; req_unsigned = 1'b0;
    addr = '0; wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick; tick;
    check("reset_rdata", rdata, 32'h0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {30'd0, err}, 32'd0);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_wstrb", {28'd0, mem_wstrb}, 32'd0);
    rst = 1'b0;

    access(1'b1, SIZE_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 3, 32'h100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    access(1'b0, SIZE_BYTE, 1'b0, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80);
    access(1'b0, SIZE_BYTE, 1'b1, 32'h103, 32'h0, 32'h80FF_FF7F, 1, 32'h100, 4'b0000, 32'h0, 32'h0000_0080);
    access(1'b1, SIZE_HALF, 1'b0, 32'h202, 32'hABCD_1234, 32'h0, 0, 32'h200, 4'b1100, 32'h1234_1234, 32'h0000_0080);
    access(1'b0, SIZE_HALF, 1'b0, 32'h202, 32'h0, 32'h8001_7FFF, 2, 32'h200, 4'b0000, 32'h0, 32'hFFFF_8001);
    access(1'b0, SIZE_HALF, 1'b1, 32'h200, 32'h0, 32'h1234_F00D, 0, 32'h200, 4'b0000, 32'h0, 32'h0000_F00D);
    access(1'b1, SIZE_BYTE, 1'b0, 32'h301, 32'hFFFF_FFA5, 32'h0, 1, 32'h300, 4'b0010, 32'hA5A5_A5A5, 32'h0000_F00D);
    access(1'b0, SIZE_BYTE, 1'b0, 32'h401, 32'h0, 32'h1234_AB00, 0, 32'h400, 4'b0000, 32'h0, 32'hFFFF_FFAB);
    access(1'b0, SIZE_BYTE, 1'b0, 32'h400, 32'h0, 32'h0000_007F, 0, 32'h400, 4'b0000, 32'h0, 32'h0000_007F);

`ifdef LSU_MISALIGN_CHECK_EN
    tick;
    req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_WORD; req_unsigned = 1'b0; addr = 32'h101;
    resp_q.push_back('{32'h0000_007F, 2'b01, cyc, 1});
    tick;
    req_valid = 1'b0;
    check("misalign_no_mem_req", {31'd0, mem_req}, 32'd0);
    tick;
`else
    access(1'b0, SIZE_WORD, 1'b0, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 32'h100, 4'b0000, 32'h0, 32'hCAFE_F00D);
`endif

    // Timeout: memory never answers.
    tick;
    req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_WORD; req_unsigned = 1'b0; addr = 32'h500;
    resp_q.push_back('{32'h0, 2'b10, cyc, MAX_WAIT + 1});
    tick;
    req_valid = 1'b0;
    check("timeout_mem_req_waiting", {31'd0, mem_req}, 32'd1);
    repeat (MAX_WAIT) tick;
    check("timeout_done_mem_req", {31'd0, mem_req}, 32'd0);
    tick;
    check("timeout_after_mem_req", {31'd0, mem_req}, 32'd0);

    // Reset mid-wait abandons the access.
    tick;
    req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_WORD; addr = 32'h700;
    tick;
    req_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick;
    mem_ready = 1'b0;
    check("abort_late_ready_done", {31'd0, done}, 32'd0);
    check("abort_rdata", rdata, 32'h0);
    access(1'b0, SIZE_WORD, 1'b0, 32'h600, 32'h0, 32'h1357_9BDF, 0, 32'h600, 4'b0000, 32'h0, 32'h1357_9BDF);

    repeat (3) tick;
    check("resp_queue_drained", resp_q.size(), 32'd0);
    check("mem_queue_drained", mem_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
